// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit.
package riscv_ctrl_pkg;

  // Opcodes of the supported instruction classes
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  // Branch funct3 codes
  localparam logic [2:0] F3Beq = 3'b000;
  localparam logic [2:0] F3Bne = 3'b001;
  localparam logic [2:0] F3Blt = 3'b100;
  localparam logic [2:0] F3Bge = 3'b101;

  // ALU operations
  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  // Immediate formats
  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmU = 3'b011;
  localparam logic [2:0] ImmJ = 3'b100;

  // Result bus sources
  localparam logic [1:0] ResAluOut = 2'b00;
  localparam logic [1:0] ResData   = 2'b01;
  localparam logic [1:0] ResAlu    = 2'b10;
  localparam logic [1:0] ResImm    = 2'b11;

  // ALU operand sources
  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;
  localparam logic [1:0] SrcBRs2   = 2'b00;
  localparam logic [1:0] SrcBImm   = 2'b01;
  localparam logic [1:0] SrcBFour  = 2'b10;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBranch,
    StJal,
    StJalr,
    StLink,
    StLui
  } state_e;

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7 to the ALU operation for R-type and I-type ALU instructions.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  // op bit 5 separates R-type from I-type, so addi never becomes sub
  always_comb begin
    alu_control = AluAdd;
    unique case (funct3)
      3'b000:  alu_control = (op5 && funct7b5) ? AluSub : AluAdd;
      3'b010:  alu_control = AluSlt;
      3'b110:  alu_control = AluOr;
      3'b111:  alu_control = AluAnd;
      default: alu_control = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle RV32I core.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       neg,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] aluControl,
  output logic [2:0] immSrc,
  output logic       illegal
);

  state_e     state_q, state_d;
  logic [2:0] dec_alu;
  logic       taken;

  alu_decoder u_alu_decoder (
    .op5         (op[5]),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (dec_alu)
  );

  // State register, reset straight to FETCH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Immediate format decoded from the opcode alone
  always_comb begin
    immSrc = ImmI;
    unique case (op)
      OpStore:  immSrc = ImmS;
      OpBranch: immSrc = ImmB;
      OpLui:    immSrc = ImmU;
      OpJal:    immSrc = ImmJ;
      default:  immSrc = ImmI;
    endcase
  end

  // Branch condition from the subtraction flags
  always_comb begin
    taken = 1'b0;
    unique case (funct3)
      F3Beq:   taken = zero;
      F3Bne:   taken = ~zero;
      F3Blt:   taken = neg;
      F3Bge:   taken = ~neg;
      default: taken = 1'b0;
    endcase
  end

  // Next state and per-state datapath controls
  always_comb begin
    state_d    = state_q;
    pcWrite    = 1'b0;
    adrSrc     = 1'b0;
    memWrite   = 1'b0;
    irWrite    = 1'b0;
    regWrite   = 1'b0;
    resultSrc  = ResAluOut;
    aluSrcA    = SrcAPc;
    aluSrcB    = SrcBRs2;
    aluControl = AluAdd;
    illegal    = 1'b0;

    unique case (state_q)
      StFetch: begin
        irWrite   = 1'b1;
        aluSrcB   = SrcBFour;
        resultSrc = ResAlu;
        pcWrite   = 1'b1;
        state_d   = StDecode;
      end
      StDecode: begin
        // Branch/jal target is computed here and latched in ALUOut
        aluSrcA = SrcAOldPc;
        aluSrcB = SrcBImm;
        unique case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = StExecR;
          OpItype:         state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpLui:           state_d = StLui;
          default: begin
            illegal = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        aluSrcA = SrcARs1;
        aluSrcB = SrcBImm;
        state_d = (op == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        adrSrc  = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        resultSrc = ResData;
        regWrite  = 1'b1;
        state_d   = StFetch;
      end
      StMemWrite: begin
        adrSrc   = 1'b1;
        memWrite = 1'b1;
        state_d  = StFetch;
      end
      StExecR: begin
        aluSrcA    = SrcARs1;
        aluSrcB    = SrcBRs2;
        aluControl = dec_alu;
        state_d    = StAluWb;
      end
      StExecI: begin
        aluSrcA    = SrcARs1;
        aluSrcB    = SrcBImm;
        aluControl = dec_alu;
        state_d    = StAluWb;
      end
      StAluWb: begin
        regWrite = 1'b1;
        state_d  = StFetch;
      end
      StBranch: begin
        // PC loads the target held in ALUOut when the compare says taken
        aluSrcA    = SrcARs1;
        aluSrcB    = SrcBRs2;
        aluControl = AluSub;
        pcWrite    = taken;
        state_d    = StFetch;
      end
      StJal: begin
        pcWrite = 1'b1;
        state_d = StLink;
      end
      StJalr: begin
        aluSrcA   = SrcARs1;
        aluSrcB   = SrcBImm;
        resultSrc = ResAlu;
        pcWrite   = 1'b1;
        state_d   = StLink;
      end
      StLink: begin
        // rd <- oldPC + 4
        aluSrcA   = SrcAOldPc;
        aluSrcB   = SrcBFour;
        resultSrc = ResAlu;
        regWrite  = 1'b1;
        state_d   = StFetch;
      end
      StLui: begin
        resultSrc = ResImm;
        regWrite  = 1'b1;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // Reset holds every write enable low; selects already show FETCH
    if (rst) begin
      pcWrite  = 1'b0;
      memWrite = 1'b0;
      irWrite  = 1'b0;
      regWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: stimulus queues per-cycle expected controls, a negedge monitor compares.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, neg;
  logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal;
  logic [1:0] resultSrc, aluSrcA, aluSrcB;
  logic [2:0] aluControl, immSrc;

  multicycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .neg        (neg),
    .pcWrite    (pcWrite),
    .adrSrc     (adrSrc),
    .memWrite   (memWrite),
    .irWrite    (irWrite),
    .regWrite   (regWrite),
    .resultSrc  (resultSrc),
    .aluSrcA    (aluSrcA),
    .aluSrcB    (aluSrcB),
    .aluControl (aluControl),
    .immSrc     (immSrc),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [17:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  logic [17:0] act;
  assign act = {pcWrite, adrSrc, memWrite, irWrite, regWrite, resultSrc, aluSrcA, aluSrcB,
                aluControl, immSrc, illegal};

  // {pcW, adrSrc, memW, irW, regW, resultSrc, srcA, srcB, aluCtl, immSrc, illegal}
  function automatic logic [17:0] vec(logic pcw, logic adr, logic mw, logic irw, logic rw,
                                      logic [1:0] rs, logic [1:0] a, logic [1:0] b,
                                      logic [2:0] alu, logic [2:0] imm, logic ill);
    return {pcw, adr, mw, irw, rw, rs, a, b, alu, imm, ill};
  endfunction

  // Monitor: one expected vector per cycle while the scoreboard holds entries
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (act !== e.v) begin
        n_mis++;
        $display("FAIL %s: got %b required %b", e.name, act, e.v);
      end
    end
  end

  task automatic push(string name, logic [17:0] v);
    exp_t e;
    e.name = name;
    e.v    = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    int i = 0;
    while (sb.size() != 0 && i < 40) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL drain: %0d entries pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Wait out the previous instruction, then land just after the edge that enters FETCH
  task automatic next_slot();
    drain();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction and queue its expected control vectors (first `limit` cycles)
  task automatic issue(string nm, logic [6:0] o, logic [2:0] f3, logic f7, logic z, logic n,
                       logic [2:0] imm, logic [2:0] alu, logic tk, int limit);
    logic [17:0] l[$];
    op = o; funct3 = f3; funct7b5 = f7; zero = z; neg = n;
    l.push_back(vec(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0));       // FETCH
    if (o == 7'b1111111) begin
      l.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 1));     // DECODE illegal
    end else begin
      l.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0));     // DECODE
    end
    case (o)
      7'b0000011: begin
        l.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, imm, 0));   // MEM_ADR
        l.push_back(vec(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0));   // MEM_READ
        l.push_back(vec(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, imm, 0));   // MEM_WB
      end
      7'b0100011: begin
        l.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, imm, 0));
        l.push_back(vec(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0));   // MEM_WRITE
      end
      7'b0110011: begin
        l.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, imm, 0));      // EXEC_R
        l.push_back(vec(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0));   // ALU_WB
      end
      7'b0010011: begin
        l.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, imm, 0));      // EXEC_I
        l.push_back(vec(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0));
      end
      7'b1100011: begin
        l.push_back(vec(tk, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, imm, 0));  // BRANCH
      end
      7'b1101111: begin
        l.push_back(vec(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0));   // JAL
        l.push_back(vec(0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 3'b000, imm, 0));   // LINK
      end
      7'b1100111: begin
        l.push_back(vec(1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, 3'b000, imm, 0));   // JALR
        l.push_back(vec(0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 3'b000, imm, 0));
      end
      7'b0110111: begin
        l.push_back(vec(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b000, imm, 0));   // LUI
      end
      default: ;
    endcase
    for (int i = 0; i < l.size() && i < limit; i++) push($sformatf("%s.c%0d", nm, i), l[i]);
  endtask

  initial begin
    rst = 1'b1; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0; neg = 1'b0;
    // Under reset: FETCH selects, no enables
    push("rst0", vec(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0));
    push("rst1", vec(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0));
    next_slot();
    rst = 1'b0;

    // lw aborted in MEM_READ by reset
    issue("lw_abort", 7'b0000011, 3'b010, 0, 0, 0, 3'b000, 3'b000, 0, 3);
    next_slot();
    rst = 1'b1;
    push("rst_mid0", vec(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0));
    push("rst_mid1", vec(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0));
    next_slot();
    rst = 1'b0;
    issue("lw", 7'b0000011, 3'b010, 0, 1, 1, 3'b000, 3'b000, 0, 99);

    next_slot(); issue("sw", 7'b0100011, 3'b010, 0, 0, 0, 3'b001, 3'b000, 0, 99);
    next_slot(); issue("sub", 7'b0110011, 3'b000, 1, 0, 0, 3'b000, 3'b001, 0, 99);
    next_slot(); issue("slt", 7'b0110011, 3'b010, 0, 0, 0, 3'b000, 3'b101, 0, 99);
    next_slot(); issue("or", 7'b0110011, 3'b110, 0, 0, 0, 3'b000, 3'b011, 0, 99);
    next_slot(); issue("addi", 7'b0010011, 3'b000, 1, 0, 0, 3'b000, 3'b000, 0, 99);
    next_slot(); issue("andi", 7'b0010011, 3'b111, 0, 0, 0, 3'b000, 3'b010, 0, 99);
    next_slot(); issue("beq_t", 7'b1100011, 3'b000, 0, 1, 0, 3'b010, 3'b000, 1, 99);
    next_slot(); issue("beq_nt", 7'b1100011, 3'b000, 0, 0, 0, 3'b010, 3'b000, 0, 99);
    next_slot(); issue("bne_t", 7'b1100011, 3'b001, 0, 0, 0, 3'b010, 3'b000, 1, 99);
    next_slot(); issue("blt_t", 7'b1100011, 3'b100, 0, 0, 1, 3'b010, 3'b000, 1, 99);
    next_slot(); issue("bge_nt", 7'b1100011, 3'b101, 0, 0, 1, 3'b010, 3'b000, 0, 99);
    next_slot(); issue("br010", 7'b1100011, 3'b010, 0, 1, 1, 3'b010, 3'b000, 0, 99);
    next_slot(); issue("jal", 7'b1101111, 3'b000, 0, 1, 1, 3'b100, 3'b000, 0, 99);
    next_slot(); issue("jalr", 7'b1100111, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0, 99);
    next_slot(); issue("lui", 7'b0110111, 3'b000, 0, 0, 0, 3'b011, 3'b000, 0, 99);
    next_slot(); issue("ill", 7'b1111111, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0, 99);
    // FETCH must follow the illegal DECODE directly
    next_slot(); issue("tail", 7'b0110111, 3'b000, 0, 0, 0, 3'b011, 3'b000, 0, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multi-cycle RV32I core. A Moore FSM sequences fetch, decode, address/execute, memory and write-back over a shared ALU and a single unified memory. It generates every datapath select and write enable, including the `immSrc` code consumed by the immediate extender. One instruction completes before the next fetch begins; there is no overlap.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `op` in 7: instruction register bits [6:0].
- `funct3` in 3: instruction register bits [14:12].
- `funct7b5` in 1: instruction register bit 30.
- `zero` in 1: ALU result == 0.
- `neg` in 1: ALU result sign bit, used for a signed compare.
- `pcWrite` out 1: PC register enable.
- `adrSrc` out 1: memory address select. 0 = PC, 1 = result bus.
- `memWrite` out 1: memory write enable.
- `irWrite` out 1: enables the IR and old-PC registers.
- `regWrite` out 1: register file write enable.
- `resultSrc` out 2: result bus select.
  - 00 = ALUOut register
  - 01 = memory data register
  - 10 = ALU result direct
  - 11 = immExt
- `aluSrcA` out 2: ALU A operand. 00 = PC, 01 = oldPC, 10 = rs1 register.
- `aluSrcB` out 2: ALU B operand. 00 = rs2 register, 01 = immExt, 10 = constant 4.
- `aluControl` out 3: ALU operation. 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `immSrc` out 3: immediate format. 000 I, 001 S, 010 B, 011 U, 100 J.
- `illegal` out 1: one-cycle pulse in DECODE when the opcode is unsupported.

## Operation
- Supported instructions: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq/bne/blt/bge, jal, jalr, lui.
- `immSrc` is combinational from `op`:
  - lw, I-ALU, jalr → 000
  - sw → 001
  - branch → 010
  - lui → 011
  - jal → 100
  - any other opcode → 000
- Default output values in every state unless listed below: all enables 0, all selects 0, aluControl = add.
- States, outputs and transitions:
  - FETCH: adrSrc=0, irWrite=1, aluSrcA=00, aluSrcB=10, add, resultSrc=10, pcWrite=1 → DECODE.
  - DECODE: aluSrcA=01, aluSrcB=01, add (ALUOut ← branch/jal target). Next state by opcode:
    - lw/sw → MEM_ADR
    - R-type → EXEC_R
    - I-ALU → EXEC_I
    - branch → BRANCH
    - jal → JAL
    - jalr → JALR
    - lui → LUI
    - other → FETCH with `illegal`=1
  - MEM_ADR: aluSrcA=10, aluSrcB=01, add → MEM_READ if lw, MEM_WRITE if sw.
  - MEM_READ: adrSrc=1, resultSrc=00 → MEM_WB.
  - MEM_WB: resultSrc=01, regWrite=1 → FETCH.
  - MEM_WRITE: adrSrc=1, resultSrc=00, memWrite=1 → FETCH.
  - EXEC_R: aluSrcA=10, aluSrcB=00, aluControl from the ALU decoder → ALU_WB.
  - EXEC_I: aluSrcA=10, aluSrcB=01, aluControl from the ALU decoder → ALU_WB.
  - ALU_WB: resultSrc=00, regWrite=1 → FETCH.
  - BRANCH: aluSrcA=10, aluSrcB=00, sub, resultSrc=00, pcWrite=taken → FETCH.
    - taken is: beq `zero`; bne !`zero`; blt `neg`; bge !`neg`.
    - Any other funct3 is not taken.
  - JAL: resultSrc=00, pcWrite=1 → LINK.
  - JALR: aluSrcA=10, aluSrcB=01, add, resultSrc=10, pcWrite=1 → LINK.
  - LINK: aluSrcA=01, aluSrcB=10, add, resultSrc=10, regWrite=1 (rd ← oldPC+4) → FETCH.
  - LUI: resultSrc=11, regWrite=1 → FETCH.
- ALU decoder behaviour:
  - funct3 000 → add, except R-type with funct7b5=1 → sub (addi is always add).
  - funct3 010 → slt.
  - funct3 110 → or.
  - funct3 111 → and.
  - Any other funct3 → add.
- An illegal instruction behaves as a NOP: the PC has already advanced by 4 and no register or memory write occurs.

## Timing
- The state register updates on the rising edge of `clk`. Outputs are combinational from state, IR fields and flags; there are no output registers.
- Cycles per instruction, FETCH through last state:
  - lw 5
  - sw, R-type, I-ALU, jal, jalr 4
  - branch, lui 3
  - illegal 2
- Reset:
  - `rst` high forces the state to FETCH immediately, independent of `clk`.
  - While `rst` is high, pcWrite, irWrite, regWrite, memWrite and illegal are forced to 0. Selects show their FETCH values.
  - Reset asserted mid-instruction abandons the instruction. The first fetch occurs on the first rising edge after deassertion.
- Flags `zero`/`neg` are sampled combinationally in BRANCH only. They are ignored in every other state.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - opcode constants (0000011, 0100011, 0110011, 0010011, 1100011, 1101111, 1100111, 0110111)
  - the state enum
  - aluControl, immSrc, resultSrc, aluSrcA and aluSrcB encodings
- One sub-module: `alu_decoder`, which is combinational and takes op bit 5, funct3 and funct7b5.

## Test plan
- Reset: assert `rst` mid-MEM_READ → state is FETCH at once and all enables are 0. After release, irWrite=1 and pcWrite=1 in the first cycle.
- lw (op=0000011): the state sequence is FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, FETCH.
  - immSrc=000.
  - regWrite=1 only in MEM_WB, with resultSrc=01.
- sw (op=0100011): immSrc=001. memWrite=1 with adrSrc=1 in exactly one cycle, and regWrite is never 1.
- R-type sub (funct3=000, funct7b5=1): aluControl=001 in EXEC_R. Repeat with addi and funct7b5=1 → aluControl=000.
- Branches, immSrc=010:
  - beq with zero=1 → pcWrite=1 in BRANCH.
  - beq with zero=0 → pcWrite=0.
  - bge with neg=1 → pcWrite=0.
  - funct3=010 → pcWrite=0.
  - Each branch takes 3 cycles.
- Jumps, lui and illegal opcodes:
  - jal → immSrc=100, pcWrite in JAL and regWrite in LINK.
  - lui → resultSrc=11 with regWrite=1, 3 cycles.
  - op=1111111 → `illegal` pulses once and the next state is FETCH, with no writes.
